apb_timeout_guard: RTL and testbench

- Sits directly downstream of the AXI-to-APB bridge's slave-select mux, between the bridge's per-slave APB port and the APB slaves.
- Passes APB transfers through unchanged and counts ACCESS-phase cycles.
- If the selected slave does not assert pready within TIMEOUT_CYCLES, it aborts the transfer towards the slave and returns a synthesized error response to the bridge.
- The bridge therefore never hangs on a dead slave, and the AXI side receives SLVERR.

---
 rtl/apb_timeout_guard.sv | 152 +++++++++++++++
 tb/tb_apb_timeout_guard.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timeout_guard.sv
// apb_timeout_guard: APB pass-through that aborts transfers whose slave stalls too long.
// Latency: zero added latency on s_*/m_* paths; abort response appears one cycle after the counter reaches TIMEOUT_CYCLES.
// Backpressure: slave pready stalls are passed through until the timeout fires, then the guard completes the transfer itself.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m_psel..m_pwdata          APB request from the bridge (m_psel is one-hot)
//   m_prdata/pready/pslverr   per-slave APB response lanes back to the bridge
//   s_psel..s_pwdata          APB request towards the slaves
//   s_prdata/pready/pslverr   per-slave APB response lanes from the slaves
//   to_count/to_slave/to_addr abort statistics: saturating count, last slave index, last paddr
//
// Optional feature (macro APB_TIMEOUT_IRQ_EN): adds to_irq (sticky, set on each abort)
// and to_irq_clr (single-cycle clear pulse; a simultaneous set wins).
// TIMEOUT_CYCLES == 0 turns the block into a pure pass-through.

module apb_timeout_guard #(
  parameter int          NUM_SLAVES     = 8,
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_SLAVES-1:0]                         m_psel,
  input  logic                                          m_penable,
  input  logic                                          m_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0]                     m_paddr,
  input  logic [31:0]                                   m_pwdata,
  output logic [NUM_SLAVES*32-1:0]                      m_prdata,
  output logic [NUM_SLAVES-1:0]                         m_pready,
  output logic [NUM_SLAVES-1:0]                         m_pslverr,
  output logic [NUM_SLAVES-1:0]                         s_psel,
  output logic                                          s_penable,
  output logic                                          s_pwrite,
  output logic [APB_ADDR_WIDTH-1:0]                     s_paddr,
  output logic [31:0]                                   s_pwdata,
  input  logic [NUM_SLAVES*32-1:0]                      s_prdata,
  input  logic [NUM_SLAVES-1:0]                         s_pready,
  input  logic [NUM_SLAVES-1:0]                         s_pslverr,
`ifdef APB_TIMEOUT_IRQ_EN
  output logic                                          to_irq,
  input  logic                                          to_irq_clr,
`endif
  output logic [15:0]                                   to_count,
  output logic [(NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1)-1:0] to_slave,
  output logic [APB_ADDR_WIDTH-1:0]                     to_addr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          idx_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      in_abort;
  logic                      xfer_active;

  // Encoded position of the (single) set bit of m_psel.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (m_psel[i]) idx = IDX_W'(i);
    end
  end

  assign xfer_active = (|m_psel) && m_penable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      to_count <= '0;
      to_slave <= '0;
      to_addr  <= '0;
`ifdef APB_TIMEOUT_IRQ_EN
      to_irq   <= 1'b0;
`endif
    end else begin
`ifdef APB_TIMEOUT_IRQ_EN
      // Clear is evaluated first so that a set in ABORT below overrides it.
      if (to_irq_clr) to_irq <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if ((TIMEOUT_CYCLES != 0) && xfer_active) begin
            state  <= ACCESS;
            cnt    <= CNT_W'(1);
            idx_q  <= idx;
            addr_q <= m_paddr;
          end
        end
        ACCESS: begin
          // A master that abandons the transfer is treated like a completion: nothing recorded.
          if (!xfer_active || s_pready[idx_q]) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            state <= ABORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ABORT: begin
          state    <= IDLE;
          cnt      <= '0;
          to_count <= (to_count == 16'hFFFF) ? to_count : to_count + 16'd1;
          to_slave <= idx_q;
          to_addr  <= addr_q;
`ifdef APB_TIMEOUT_IRQ_EN
          to_irq   <= 1'b1;
`endif
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign in_abort  = (state == ABORT);

  // Request path: withdrawn from the slave only during the abort cycle.
  assign s_psel    = in_abort ? '0 : m_psel;
  assign s_penable = in_abort ? 1'b0 : m_penable;
  assign s_pwrite  = m_pwrite;
  assign s_paddr   = m_paddr;
  assign s_pwdata  = m_pwdata;

  // Response path: only the aborted lane is overridden; the slave's own answer on it is dropped.
  always_comb begin
    m_pready  = s_pready;
    m_pslverr = s_pslverr;
    m_prdata  = s_prdata;
    if (in_abort) begin
      m_pready[idx_q]           = 1'b1;
      m_pslverr[idx_q]          = 1'b1;
      m_prdata[idx_q*32 +: 32]  = TIMEOUT_RDATA;
    end
  end

  a_psel_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(m_psel))
    else $error("m_psel has more than one bit set");

endmodule

// File: tb/tb_apb_timeout_guard.sv
module tb_apb_timeout_guard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst0;
  logic [7:0]   m_psel;
  logic         m_penable, m_pwrite;
  logic [11:0]  m_paddr;
  logic [31:0]  m_pwdata;
  logic [255:0] s_prdata;
  logic [7:0]   s_pready, s_pslverr;

  logic [255:0] m_prdata4, m_prdata0;
  logic [7:0]   m_pready4, m_pready0, m_pslverr4, m_pslverr0, s_psel4, s_psel0;
  logic         s_penable4, s_penable0, s_pwrite4, s_pwrite0;
  logic [11:0]  s_paddr4, s_paddr0, to_addr4, to_addr0;
  logic [31:0]  s_pwdata4, s_pwdata0;
  logic [15:0]  to_count4, to_count0;
  logic [2:0]   to_slave4, to_slave0;
`ifdef APB_TIMEOUT_IRQ_EN
  logic         to_irq4, to_irq0;
`endif
  logic         irq_clr;

  apb_timeout_guard #(.NUM_SLAVES(8), .APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut4 (
    .clk(clk), .rst(rst4), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata4), .m_pready(m_pready4),
    .m_pslverr(m_pslverr4), .s_psel(s_psel4), .s_penable(s_penable4), .s_pwrite(s_pwrite4),
    .s_paddr(s_paddr4), .s_pwdata(s_pwdata4), .s_prdata(s_prdata), .s_pready(s_pready),
    .s_pslverr(s_pslverr),
`ifdef APB_TIMEOUT_IRQ_EN
    .to_irq(to_irq4), .to_irq_clr(irq_clr),
`endif
    .to_count(to_count4), .to_slave(to_slave4), .to_addr(to_addr4));

  apb_timeout_guard #(.NUM_SLAVES(8), .APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(0), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut0 (
    .clk(clk), .rst(rst0), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata0), .m_pready(m_pready0),
    .m_pslverr(m_pslverr0), .s_psel(s_psel0), .s_penable(s_penable0), .s_pwrite(s_pwrite0),
    .s_paddr(s_paddr0), .s_pwdata(s_pwdata0), .s_prdata(s_prdata), .s_pready(s_pready),
    .s_pslverr(s_pslverr),
`ifdef APB_TIMEOUT_IRQ_EN
    .to_irq(to_irq0), .to_irq_clr(irq_clr),
`endif
    .to_count(to_count0), .to_slave(to_slave0), .to_addr(to_addr0));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // act selects which instance the master talks to: 0 -> TIMEOUT_CYCLES=4, 1 -> TIMEOUT_CYCLES=0
  bit act = 1'b0;

  // Reference model of the TIMEOUT_CYCLES=4 instance's status registers.
  int          m_count = 0;
  int          m_slave = 0;
  logic [11:0] m_addr  = '0;
  bit          m_irq   = 1'b0;

  typedef struct {
    int          sl;
    logic [31:0] rdata;
    logic        err;
    bit          abrt;
    int          cyc;
  } exp_t;
  exp_t q[$];

  // Monitor: counts penable cycles of the current transfer and checks each completion.
  int mcyc = 0;
  always @(negedge clk) begin
    logic [7:0]  rdy, err, sps;
    logic        spe;
    logic [31:0] rd;
    logic [7:0]  lane;
    int          id;
    exp_t        e;
    rdy = act ? m_pready0   : m_pready4;
    err = act ? m_pslverr0  : m_pslverr4;
    sps = act ? s_psel0     : s_psel4;
    spe = act ? s_penable0  : s_penable4;
    if ((|m_psel) && m_penable) begin
      id = 0;
      for (int i = 0; i < 8; i++) if (m_psel[i]) id = i;
      rd = act ? m_prdata0[id*32 +: 32] : m_prdata4[id*32 +: 32];
      if (rdy[id]) begin
        if (q.size() == 0) begin
          chk("unexpected_response", 64'(id), 64'hFFFF);
        end else begin
          e = q.pop_front();
          lane = 8'(1 << e.sl);
          chk("resp_slave", 64'(id), 64'(e.sl));
          chk("resp_cycle", 64'(mcyc), 64'(e.cyc));
          chk("resp_prdata", rd, e.rdata);
          chk("resp_pslverr", err[id], e.err);
          chk("pready_lanes", rdy, s_pready | (e.abrt ? lane : 8'h00));
          chk("pslverr_lanes", err, s_pslverr | (e.abrt ? lane : 8'h00));
          chk("s_psel", sps, e.abrt ? 8'h00 : m_psel);
          chk("s_penable", spe, e.abrt ? 1'b0 : 1'b1);
        end
        mcyc = 0;
      end else begin
        mcyc++;
      end
    end else begin
      mcyc = 0;
    end
  end

  task automatic status_check();
    if (!act) begin
      chk("to_count", to_count4, 64'(m_count));
      chk("to_slave", to_slave4, 64'(m_slave));
      chk("to_addr", to_addr4, m_addr);
`ifdef APB_TIMEOUT_IRQ_EN
      chk("to_irq", to_irq4, m_irq);
`endif
    end
    chk("t0_to_count", to_count0, 0);
    chk("t0_to_addr", to_addr0, 0);
  endtask

  // One APB transfer; call and return at posedge+1. The slave asserts pready in
  // penable cycle d (cycle 0 = first penable cycle). rst_cyc/clr_cyc < 0 mean unused.
  task automatic xfer(input int sl, input logic [11:0] addr, input logic [31:0] rd,
                      input int d, input int rst_cyc, input int clr_cyc);
    int   t, base, resp, cyc;
    bit   ab, done;
    logic e;
    logic [7:0] rdy;
    exp_t x;
    t    = act ? 0 : 4;
    e    = 1'($urandom_range(0, 1));
    base = (rst_cyc >= 0) ? rst_cyc : 0;
    ab   = (t != 0) && (d > base + t);
    resp = ab ? base + t + 1 : d;
    x.sl = sl; x.rdata = ab ? 32'hDEAD_BEEF : rd; x.err = ab ? 1'b1 : e; x.abrt = ab; x.cyc = resp;
    q.push_back(x);
    if (!act) begin
      if (rst_cyc >= 0) begin m_count = 0; m_slave = 0; m_addr = '0; m_irq = 1'b0; end
      if (clr_cyc >= 0 && clr_cyc <= resp) m_irq = 1'b0;
      if (ab) begin
        if (m_count < 16'hFFFF) m_count++;
        m_slave = sl; m_addr = addr; m_irq = 1'b1;
      end
    end
    m_psel = 8'(1 << sl); m_penable = 1'b0; m_paddr = addr;
    m_pwrite = 1'($urandom_range(0, 1)); m_pwdata = $urandom;
    for (int i = 0; i < 8; i++) s_prdata[i*32 +: 32] = $urandom;
    s_prdata[sl*32 +: 32] = rd;
    s_pready = 8'($urandom) & ~8'(1 << sl);
    s_pslverr = 8'($urandom);
    @(posedge clk); #1;
    m_penable = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done) begin
      s_pready[sl]  = (cyc == d);
      s_pslverr[sl] = (cyc == d) ? e : 1'($urandom);
      irq_clr       = (cyc == clr_cyc);
      if (cyc == rst_cyc) begin
        #1 rst4 = 1'b1;
        #1 rst4 = 1'b0;
      end
      @(negedge clk);
      rdy = act ? m_pready0 : m_pready4;
      if (rdy[sl]) done = 1'b1;
      else if (cyc >= 3000) begin
        chk("xfer_timeout_bound", 64'(cyc), 64'(resp));
        done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_psel = '0; m_penable = 1'b0; s_pready = '0; irq_clr = 1'b0;
    status_check();
  endtask

  initial begin
    rst4 = 1'b1; rst0 = 1'b1; irq_clr = 1'b0;
    m_psel = 8'h10; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
    s_prdata = '0; s_pready = '0; s_pslverr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_to_count", to_count4, 0);
    chk("reset_to_slave", to_slave4, 0);
    chk("reset_to_addr", to_addr4, 0);
    chk("reset_passthru_psel", s_psel4, 8'h10);
    m_psel = '0;
    rst4 = 1'b0; rst0 = 1'b0;
    @(posedge clk); #1;

    // Directed cases on the TIMEOUT_CYCLES=4 instance.
    xfer(2, 12'h010, 32'h1234_5678, 2, -1, -1);     // normal completion
    xfer(5, 12'h3A0, 32'h0BAD_0BAD, 1000, -1, -1);  // dead slave -> abort
    xfer(3, 12'h044, 32'hCAFE_0004, 4, -1, -1);     // ready exactly at the limit
    xfer(6, 12'h155, 32'h0000_0005, 5, -1, -1);     // ready only in the abort cycle
    xfer(1, 12'h200, 32'hA5A5_0001, 0, -1, -1);     // immediately after the abort
    xfer(4, 12'h2F0, 32'h5555_AAAA, 6, 3, -1);      // reset in counter cycle 3
    xfer(0, 12'h001, 32'h7777_0000, 1, -1, -1);

`ifdef APB_TIMEOUT_IRQ_EN
    rst4 = 1'b1; #1 rst4 = 1'b0;
    m_count = 0; m_slave = 0; m_addr = '0; m_irq = 1'b0;
    @(posedge clk); #1;
    xfer(1, 12'h111, 32'h1, 1000, -1, -1);
    xfer(3, 12'h333, 32'h3, 1000, -1, -1);
    xfer(6, 12'h666, 32'h6, 1000, -1, 5);           // clear coincides with the abort exit edge
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    m_irq = 1'b0;
    status_check();
`endif

    // Randomized traffic, including back-to-back transfers.
    for (int n = 0; n < 40; n++) begin
      xfer($urandom_range(0, 7), 12'($urandom), $urandom, $urandom_range(0, 7), -1, -1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Guard disabled: long stall must be passed through untouched.
    rst4 = 1'b1;
    act  = 1'b1;
    @(posedge clk); #1;
    xfer(4, 12'h0F0, 32'hFEED_F00D, 1000, -1, -1);
    for (int n = 0; n < 6; n++)
      xfer($urandom_range(0, 7), 12'($urandom), $urandom, $urandom_range(0, 9), -1, -1);

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
